// File: rtl/l1i_dm_cache.sv
// Direct-mapped L1 instruction cache with tag/valid array and line refill FSM.
// Define L1I_PERF_CNT_EN to build the 32-bit hit/miss performance counters.
module l1i_dm_cache #(
  parameter int ADDR_WIDTH  = 24,
  parameter int INSTR_WIDTH = 16,
  parameter int BUS_WIDTH   = 8,
  parameter int CACHE_BYTES = 1024,
  parameter int LINE_BYTES  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_req,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  output logic                   fetch_ready,
  output logic [INSTR_WIDTH-1:0] fetch_instr,
  output logic                   fetch_fault,
  input  logic                   flush,
  output logic                   bus_line_req,
  output logic [ADDR_WIDTH-1:0]  bus_addr,
  input  logic [BUS_WIDTH-1:0]   bus_rdata,
  input  logic                   bus_rvalid,
  input  logic                   bus_done,
  input  logic                   bus_error,
  output logic [31:0]            perf_hit_cnt,
  output logic [31:0]            perf_miss_cnt
);
  localparam int ENTRIES = CACHE_BYTES / LINE_BYTES;
  localparam int BEATS   = LINE_BYTES * 8 / BUS_WIDTH;
  localparam int LANES   = INSTR_WIDTH / BUS_WIDTH;
  localparam int WPL     = LINE_BYTES * 8 / INSTR_WIDTH;
  localparam int WORDS   = ENTRIES * WPL;
  localparam int OFF_W   = $clog2(LINE_BYTES);
  localparam int CB_W    = $clog2(CACHE_BYTES);
  localparam int IDX_W   = CB_W - OFF_W;
  localparam int TAG_W   = ADDR_WIDTH - CB_W;
  localparam int WB      = $clog2(INSTR_WIDTH / 8);
  localparam int RA_W    = CB_W - WB;
  localparam int CNT_W   = $clog2(BEATS + 1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, REFILL, REREAD, RESP, FAULT
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  a_q;
  logic [CNT_W-1:0]       cnt_q, cnt_nxt;
  logic                   fp_q;
  logic [ENTRIES-1:0]     valid_q;
  logic [TAG_W-1:0]       tag_mem [ENTRIES];
  logic [INSTR_WIDTH-1:0] mem [WORDS];
  logic [INSTR_WIDTH-1:0] rdata_q;
  logic [IDX_W-1:0]       idx_q;
  logic [RA_W-1:0]        rd_addr, wr_addr;
  logic                   ram_rd, beat_w, hit;
  logic                   tag_we, valid_set, valid_clr;
  logic                   unused_ok;

  assign idx_q   = a_q[CB_W-1:OFF_W];
  assign hit     = valid_q[idx_q] && (tag_mem[idx_q] == a_q[ADDR_WIDTH-1:CB_W]);
  assign beat_w  = (state_q == REFILL) && bus_rvalid && (cnt_q < CNT_W'(BEATS));
  assign cnt_nxt = cnt_q + CNT_W'(beat_w);
  assign wr_addr = RA_W'(int'(idx_q) * WPL + int'(cnt_q) / LANES);
  assign unused_ok = ^a_q[WB-1:0];

  assign fetch_instr = (fetch_ready && !fetch_fault) ? rdata_q : '0;
  assign bus_addr    = bus_line_req ?
                       {a_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;

  always_comb begin
    state_d      = state_q;
    ram_rd       = 1'b0;
    rd_addr      = fetch_addr[CB_W-1:WB];
    tag_we       = 1'b0;
    valid_set    = 1'b0;
    valid_clr    = 1'b0;
    fetch_ready  = 1'b0;
    fetch_fault  = 1'b0;
    bus_line_req = 1'b0;
    unique case (state_q)
      IDLE: if (fetch_req) begin
        ram_rd  = 1'b1;
        state_d = LOOKUP;
      end
      LOOKUP: if (hit) begin
        fetch_ready = 1'b1;
        state_d     = IDLE;
      end else begin
        valid_clr = 1'b1;
        state_d   = REFILL;
      end
      REFILL: begin
        bus_line_req = 1'b1;
        if (bus_error) begin
          valid_clr = 1'b1;
          state_d   = FAULT;
        end else if (bus_done) begin
          if (cnt_nxt == CNT_W'(BEATS)) begin
            tag_we    = 1'b1;
            valid_set = !(fp_q || flush);
            state_d   = REREAD;
          end else begin
            valid_clr = 1'b1;
            state_d   = FAULT;
          end
        end
      end
      REREAD: begin
        ram_rd  = 1'b1;
        rd_addr = a_q[CB_W-1:WB];
        state_d = RESP;
      end
      RESP: begin
        fetch_ready = 1'b1;
        state_d     = IDLE;
      end
      FAULT: begin
        fetch_ready = 1'b1;
        fetch_fault = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      cnt_q   <= '0;
      fp_q    <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && fetch_req) a_q <= fetch_addr;
      if (state_q == LOOKUP) cnt_q <= '0;
      else if (state_q == REFILL) cnt_q <= cnt_nxt;
      // pending flush lives only while the refill is in flight
      fp_q <= (state_q == REFILL) && (state_d == REFILL) && (fp_q || flush);
      if (flush) valid_q <= '0;
      else if (valid_clr) valid_q[idx_q] <= 1'b0;
      else if (valid_set) valid_q[idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_mem[idx_q] <= a_q[ADDR_WIDTH-1:CB_W];
  end

  always_ff @(posedge clk) begin
    if (ram_rd) rdata_q <= mem[rd_addr];
    if (beat_w)
      for (int l = 0; l < LANES; l++)
        if (l == int'(cnt_q) % LANES)
          mem[wr_addr][l*BUS_WIDTH +: BUS_WIDTH] <= bus_rdata;
  end

`ifdef L1I_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) perf_hit_cnt <= perf_hit_cnt + 32'd1;
      else perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`else
  assign perf_hit_cnt  = '0;
  assign perf_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_l1i_dm_cache.sv
// Bench for l1i_dm_cache: directed steps then random fetches vs a line-level model.
// Counter checks follow L1I_PERF_CNT_EN.
module tb_l1i_dm_cache;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [23:0] fetch_addr = '0;
  logic        fetch_ready;
  logic [15:0] fetch_instr;
  logic        fetch_fault;
  logic        flush = 1'b0;
  logic        bus_line_req;
  logic [23:0] bus_addr;
  logic [7:0]  bus_rdata = '0;
  logic        bus_rvalid = 1'b0;
  logic        bus_done = 1'b0;
  logic        bus_error = 1'b0;
  logic [31:0] perf_hit_cnt, perf_miss_cnt;

  int checks = 0;
  int failures = 0;
  int pat_mode = 0;
  bit ref_valid [64];
  int ref_tag [64];
  int hits_m = 0;
  int miss_m = 0;

  l1i_dm_cache dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_instr(fetch_instr),
    .fetch_fault(fetch_fault), .flush(flush),
    .bus_line_req(bus_line_req), .bus_addr(bus_addr),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .bus_done(bus_done), .bus_error(bus_error),
    .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (pat_mode == 0) return {4'h0, a[3:0]};
    return a[7:0] ^ a[15:8] ^ {a[20:16], a[23:21]} ^ 8'h5A;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic chk_perf();
`ifdef L1I_PERF_CNT_EN
    chk("perf_hit", perf_hit_cnt, hits_m);
    chk("perf_miss", perf_miss_cnt, miss_m);
`else
    chk("perf_hit", perf_hit_cnt, 32'd0);
    chk("perf_miss", perf_miss_cnt, 32'd0);
`endif
  endtask

  // eb: error beat, fb: flush beat (-2 = with request), de: early done beat,
  // nb: beats offered before done
  task automatic fetch(input logic [23:0] a, input int eb, input int fb,
                       input int de, input int nb);
    int idx, tg, cyc, beat, exp_lat;
    bit hit, flushed, exp_fault, refl, got;
    logic [23:0] base, al;
    logic [15:0] exp_i;
    idx  = int'(a[9:4]);
    tg   = int'(a[23:10]);
    base = {a[23:4], 4'h0};
    al   = {a[23:1], 1'b0};
    if (fb == -2) clear_model();
    hit = ref_valid[idx] && ref_tag[idx] == tg;
    if (hit) hits_m++; else miss_m++;
    exp_fault = !hit && (eb >= 0 || de >= 0);
    exp_lat = hit ? 1 : (eb >= 0) ? 3 + eb : (de >= 0) ? 3 + de : 3 + nb;
    flushed = !hit && fb >= 0 && (eb < 0 || fb <= eb) && (de < 0 || fb <= de);
    exp_i = {mem_byte(al + 24'd1), mem_byte(al)};
    fetch_req = 1'b1;
    fetch_addr = a;
    if (fb == -2) flush = 1'b1;
    cyc = 0; beat = 0; refl = 1'b0; got = 1'b0;
    while (!got && cyc < 100) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      flush = 1'b0; bus_rvalid = 1'b0; bus_done = 1'b0; bus_error = 1'b0;
      if (fetch_ready) got = 1'b1;
      else if (bus_line_req) begin
        if (!refl) chk("bus_addr", bus_addr, base);
        refl = 1'b1;
        if (beat == fb) flush = 1'b1;
        if (beat == eb) bus_error = 1'b1;
        else if (beat == de) bus_done = 1'b1;
        else begin
          bus_rvalid = 1'b1;
          bus_rdata = mem_byte(base + 24'(beat));
          if (beat == nb - 1) bus_done = 1'b1;
        end
        beat++;
      end
    end
    chk("ready_seen", got, 1);
    chk("refill_issued", refl, !hit);
    chk("latency", cyc, exp_lat);
    chk("fault", fetch_fault, exp_fault);
    if (!exp_fault) chk("instr", fetch_instr, exp_i);
    chk_perf();
    fetch_req = 1'b0;
    if (!hit) begin
      if (flushed) clear_model();
      ref_valid[idx] = !exp_fault && !flushed;
      ref_tag[idx] = tg;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int eb, fb;
    logic [23:0] a;
    clear_model();
    @(negedge clk);
    chk("rst_ready", fetch_ready, 0);
    chk("rst_instr", fetch_instr, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_line_req", bus_line_req, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk_perf();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    fetch(24'h000100, -1, -1, -1, 16);
    fetch(24'h00010E, -1, -1, -1, 16);
    fetch(24'h000104, -1, -1, -1, 16);
    fetch(24'h000500, -1, -1, -1, 16);
    fetch(24'h000100, -1, -1, -1, 16);
    fetch(24'h000220,  5, -1, -1, 16);
    fetch(24'h000220, -1, -1, -1, 16);
    fetch(24'h000340, -1,  7, -1, 16);
    fetch(24'h000340, -1, -1, -1, 16);
    fetch(24'h000342, -1, -1, -1, 16);
    fetch(24'h000340, -1, -2, -1, 16);
    fetch(24'h000660, -1, -1,  9, 16);
    fetch(24'h000660, -1, 15, -1, 16);
    fetch(24'h000662, -1, -1, -1, 16);

    // reset while a refill is in flight
    fetch_req = 1'b1;
    fetch_addr = 24'h000100;
    for (int i = 0; i < 10 && !bus_line_req; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("rstmid_line_req", bus_line_req, 1);
    for (int i = 0; i < 3; i++) begin
      bus_rvalid = 1'b1;
      bus_rdata = mem_byte(24'h000100 + 24'(i));
      @(posedge clk);
      @(negedge clk);
    end
    bus_rvalid = 1'b0;
    fetch_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstmid_ready", fetch_ready, 0);
    chk("rstmid_line_req0", bus_line_req, 0);
    chk("rstmid_bus_addr", bus_addr, 0);
    chk("rstmid_instr", fetch_instr, 0);
    chk("rstmid_fault", fetch_fault, 0);
    clear_model();
    hits_m = 0;
    miss_m = 0;
    chk_perf();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fetch(24'h000100, -1, -1, -1, 16);
    fetch(24'h000102, -1, -1, -1, 16);

    // switch to address-hashed line data
    pat_mode = 1;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    clear_model();
    fetch(24'h000100, -1, -1, -1, 16);
    fetch(24'h000780, -1, -1, -1, 18);
    fetch(24'h000780, -1, -1, -1, 16);
    fetch(24'h00078E, -1, -1, -1, 16);

    for (int n = 0; n < 60; n++) begin
      a = 24'(($urandom_range(0, 2) << 10) | ($urandom_range(0, 7) << 4)
              | $urandom_range(0, 15));
      eb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1;
      fb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : -1;
      if ($urandom_range(0, 19) == 0) fb = -2;
      fetch(a, eb, fb, -1, 16);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
